// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter feeding a memory-mapped UART over AXI4-Lite.
// Programs the baud divider once after reset, then polls status and sends one byte per grant.
// State | meaning
// INIT    | write BAUD_DIV to BASE+8, then wait for B
// IDLE    | arbitrate requesters
// POLL_AR | status read address phase
// POLL_R  | status read data phase
// DATA_W  | write byte to BASE+4
// DATA_B  | wait for data write response
// START_W | write 1 to BASE+0
// START_B | wait for start write response
module uart_tx_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [15:0] BAUD_DIV  = 16'd868,
  parameter logic [15:0] POLL_MAX  = 16'd4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [7:0]  req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_data,
  output logic        req1_ready,
  output logic [31:0] m_awaddr,
  output logic [2:0]  m_awprot,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready,
  output logic [31:0] m_araddr,
  output logic [2:0]  m_arprot,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  output logic        m_rready,
  output logic        busy,
  output logic        err,
  input  logic        err_clr
);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_POLL_AR, S_POLL_R, S_DATA_W, S_DATA_B, S_START_W, S_START_B
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_init_ph;
  logic        r_aw_done;
  logic        r_w_done;
  logic [7:0]  r_byte;
  logic [15:0] r_poll_cnt;
  logic        r_last;
  logic        r_err;

  logic w_in_wr, w_aw_hs, w_w_hs, w_wr_done, w_b_hs, w_r_hs;
  logic w_poll_busy, w_timeout, w_any, w_gnt1, w_err_set;
  logic w_unused_rdata;

  assign w_in_wr = (r_state == S_INIT && r_init_ph == 2'd1) ||
                   r_state == S_DATA_W || r_state == S_START_W;
  assign w_aw_hs   = m_awvalid && m_awready;
  assign w_w_hs    = m_wvalid && m_wready;
  assign w_wr_done = w_in_wr && (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);
  assign w_b_hs    = m_bready && m_bvalid;
  assign w_r_hs    = m_rready && m_rvalid;

  assign w_poll_busy = w_r_hs && m_rdata[1];
  assign w_timeout   = w_poll_busy && (({1'b0, r_poll_cnt} + 17'd1) >= {1'b0, POLL_MAX});
  assign w_err_set   = (w_b_hs && m_bresp != 2'b00) || (w_r_hs && m_rresp != 2'b00) || w_timeout;

  // r_last = 1 means req1 was granted last, so req0 wins a tie
  assign w_any  = req0_valid || req1_valid;
  assign w_gnt1 = req1_valid && (!req0_valid || !r_last);

  assign m_awprot = 3'b000;
  assign m_arprot = 3'b000;
  assign m_wstrb  = 4'hF;
  assign busy     = (r_state != S_IDLE);
  assign err      = r_err;
  assign w_unused_rdata = ^{m_rdata[31:2], m_rdata[0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_INIT;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    m_awvalid  = 1'b0;
    m_wvalid   = 1'b0;
    m_awaddr   = 32'h0;
    m_wdata    = 32'h0;
    m_bready   = 1'b0;
    m_arvalid  = 1'b0;
    m_araddr   = 32'h0;
    m_rready   = 1'b0;
    case (r_state)
      S_INIT: begin
        if (r_init_ph == 2'd1) begin
          m_awaddr  = BASE_ADDR + 32'd8;
          m_wdata   = {16'h0, BAUD_DIV};
          m_awvalid = !r_aw_done;
          m_wvalid  = !r_w_done;
        end else if (r_init_ph == 2'd2) begin
          m_bready = 1'b1;
          if (m_bvalid) w_next = S_IDLE;
        end
      end
      S_IDLE: begin
        if (w_any) begin
          w_next     = S_POLL_AR;
          req1_ready = w_gnt1;
          req0_ready = !w_gnt1;
        end
      end
      S_POLL_AR: begin
        m_arvalid = 1'b1;
        m_araddr  = BASE_ADDR;
        if (m_arready) w_next = S_POLL_R;
      end
      S_POLL_R: begin
        m_rready = 1'b1;
        if (m_rvalid) begin
          if (!m_rdata[1])    w_next = S_DATA_W;
          else if (w_timeout) w_next = S_IDLE;
          else                w_next = S_POLL_AR;
        end
      end
      S_DATA_W: begin
        m_awaddr  = BASE_ADDR + 32'd4;
        m_wdata   = {24'h0, r_byte};
        m_awvalid = !r_aw_done;
        m_wvalid  = !r_w_done;
        if (w_wr_done) w_next = S_DATA_B;
      end
      S_DATA_B: begin
        m_bready = 1'b1;
        if (m_bvalid) w_next = S_START_W;
      end
      S_START_W: begin
        m_awaddr  = BASE_ADDR;
        m_wdata   = 32'h1;
        m_awvalid = !r_aw_done;
        m_wvalid  = !r_w_done;
        if (w_wr_done) w_next = S_START_B;
      end
      S_START_B: begin
        m_bready = 1'b1;
        if (m_bvalid) w_next = S_IDLE;
      end
      default: w_next = S_INIT;
    endcase
  end

  // Phase 0 keeps every valid low for the first cycle out of reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_init_ph <= 2'd0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      if (r_state == S_INIT) begin
        if (r_init_ph == 2'd0)                r_init_ph <= 2'd1;
        else if (r_init_ph == 2'd1 && w_wr_done) r_init_ph <= 2'd2;
      end
      if (w_wr_done) begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end else if (w_in_wr) begin
        if (w_aw_hs) r_aw_done <= 1'b1;
        if (w_w_hs)  r_w_done  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_byte     <= 8'h0;
      r_poll_cnt <= 16'h0;
      r_last     <= 1'b1;
      r_err      <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_any) begin
        r_byte     <= w_gnt1 ? req1_data : req0_data;
        r_last     <= w_gnt1;
        r_poll_cnt <= 16'h0;
      end else if (w_poll_busy && !w_timeout) begin
        r_poll_cnt <= r_poll_cnt + 16'd1;
      end
      if (w_err_set)    r_err <= 1'b1;
      else if (err_clr) r_err <= 1'b0;
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, UART register base address.
REQ-002 SHALL have parameter BAUD_DIV, default 16'd868, divider written to the UART at init.
REQ-003 SHALL have parameter POLL_MAX, default 16'd4095, maximum status polls per byte before timeout.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports req0_valid/req1_valid, input, 1 each, requester byte pending.
REQ-007 SHALL have ports req0_data/req1_data, input, 8 each, requester byte.
REQ-008 SHALL have ports req0_ready/req1_ready, output, 1 each, one-cycle accept pulse.
REQ-009 SHALL have AXI4-Lite master ports m_aw*/m_w*/m_b*/m_ar*/m_r*, with names and widths mirroring the UART slave (addr 32, prot 3, data 32, strb 4, resp 2).
REQ-010 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-011 SHALL have port err, output, 1, sticky error flag.
REQ-012 SHALL have port err_clr, input, 1, synchronous clear of err.

Function
REQ-013 SHALL implement states INIT, IDLE, POLL_AR, POLL_R, DATA_W, DATA_B, START_W, START_B.
REQ-014 SHALL leave reset in INIT and write BAUD_DIV (zero-extended) to BASE_ADDR+8 once, then go to IDLE.
REQ-015 SHALL in IDLE grant round-robin: if only one valid, grant it; if both, grant the requester not granted last; the last-grant pointer resets to 1 (req0 wins first tie).
REQ-016 SHALL capture the granted byte and pulse the grant's reqN_ready for exactly one cycle on the IDLE->POLL_AR transition; the ungranted ready stays low.
REQ-017 SHALL in POLL_AR drive m_araddr=BASE_ADDR+0, m_arvalid=1 until m_arready; then POLL_R with m_rready=1.
REQ-018 SHALL on m_rvalid in POLL_R go to DATA_W if m_rdata[1]==0 (tx idle), else increment poll counter and return to POLL_AR.
REQ-019 SHALL, when the poll counter reaches POLL_MAX while busy, set err, discard the byte and return to IDLE.
REQ-020 SHALL in DATA_W write {24'b0,byte} to BASE_ADDR+4; in START_W write 32'h1 to BASE_ADDR+0.
REQ-021 SHALL for every write assert m_awvalid and m_wvalid in the same cycle, deassert each only after its own ready handshake, then hold m_bready=1 until m_bvalid.
REQ-022 SHALL drive m_awprot=m_arprot=3'b000 and m_wstrb=4'hF constantly.
REQ-023 SHALL set err on any m_bresp or m_rresp not equal to 2'b00 and continue the sequence unchanged.
REQ-024 SHALL clear the poll counter on every grant.
REQ-025 SHALL return from START_B to IDLE, allowing a new grant on the following cycle.
REQ-026 SHALL give err_clr priority below a same-cycle error set (set wins).
REQ-027 SHALL ignore requester valids during INIT and during non-IDLE states; held requests are granted later.
REQ-028 SHALL keep valid/address/data outputs stable while valid is high and ready is low.

Reset
REQ-029 SHALL on rst low immediately force state INIT, all valids and readies low, m_bready/m_rready low, err 0, addresses/data 0, poll counter 0, pointer 1.
REQ-030 SHALL abandon any in-flight transaction on reset without completing it; no byte is re-sent afterwards.

Verification
REQ-031 Release reset with an always-ready slave -> one write of 32'h364 to address 0x08, then busy low.
REQ-032 req0 valid with 8'h41, status reads 0 -> req0_ready one pulse; writes 0x41 to 0x04, then 0x1 to 0x00; busy falls.
REQ-033 req0 and req1 valid continuously (0x11, 0x22) -> data-register writes alternate 0x11, 0x22, 0x11, 0x22.
REQ-034 Status returns 0x2 for three reads then 0x0 -> four AR transactions before the 0x04 write.
REQ-035 POLL_MAX=3, status stuck at 0x2 -> err=1, no 0x04 write, back in IDLE; err_clr pulse -> err=0.
REQ-036 Slave returns bresp=2'b10 on data write -> err=1, start write still issued.
